// File: rtl/addsub_pipe.sv
// Pipelined signed adder/subtractor: one 4-bit ripple slice per stage, carry registered
// between stages, optional saturation, status flags and a global-stall valid/ready handshake.
module addsub_pipe #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             ovfl,
    output logic             zero,
    output logic             neg
);
    localparam int NSLICE = WIDTH / 4;
    localparam int LAST   = NSLICE - 1;

    if (WIDTH < 4 || WIDTH % 4 != 0) begin : g_width_check
        $error("addsub_pipe: WIDTH must be a positive multiple of 4");
    end

    logic advance;
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    for (genvar k = 0; k < NSLICE; k++) begin : g_slice
        localparam int REM = WIDTH - 4 * k;

        // x holds finished result nibbles at the top and the unconsumed bits of A at the bottom
        logic [WIDTH-1:0] x;
        logic [REM-1:0]   y;
        logic             cin;
        logic             sat_s;
        logic             sign_s;
        logic             v;
        logic [3:0]       lo;
        logic [3:0]       nib;
        logic             c3;
        logic             cout;
        logic [WIDTH-1:0] x_nxt;

        if (k == 0) begin : g_src
            assign x      = a;
            assign y      = b ^ {WIDTH{sub}};
            assign cin    = sub;
            assign sat_s  = sat;
            assign sign_s = a[WIDTH-1];
            assign v      = in_valid;
        end else begin : g_src
            // NOTE: non-blocking assignments, so every stage captures its predecessor's pre-edge value.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    x      <= '0;
                    y      <= '0;
                    cin    <= 1'b0;
                    sat_s  <= 1'b0;
                    sign_s <= 1'b0;
                    v      <= 1'b0;
                end else if (advance) begin
                    x      <= g_slice[k-1].x_nxt;
                    y      <= g_slice[k-1].y[WIDTH-4*k+3:4];
                    cin    <= g_slice[k-1].cout;
                    sat_s  <= g_slice[k-1].sat_s;
                    sign_s <= g_slice[k-1].sign_s;
                    v      <= g_slice[k-1].v;
                end
            end
        end

        assign lo    = {1'b0, x[2:0]} + {1'b0, y[2:0]} + {3'b000, cin};
        assign c3    = lo[3];
        assign nib   = {x[3] ^ y[3] ^ c3, lo[2:0]};
        assign cout  = (x[3] & y[3]) | (c3 & (x[3] ^ y[3]));
        assign x_nxt = (WIDTH'(nib) << (WIDTH - 4)) | (x >> 4);
    end

    logic [WIDTH-1:0] raw;
    logic [WIDTH-1:0] res;
    logic             ovf_raw;

    assign raw = g_slice[LAST].x_nxt;
    // Carry into the MSB is recovered from the MSB sum bit and its two operand bits.
    assign ovf_raw = (raw[WIDTH-1] ^ g_slice[LAST].x[3] ^ g_slice[LAST].y[3]) ^ g_slice[LAST].cout;

    always_comb begin
        res = raw;
        if (g_slice[LAST].sat_s && ovf_raw) begin
            res = g_slice[LAST].sign_s ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            sum       <= '0;
            carry_out <= 1'b0;
            ovfl      <= 1'b0;
            zero      <= 1'b0;
            neg       <= 1'b0;
        end else if (advance) begin
            out_valid <= g_slice[LAST].v;
            sum       <= res;
            carry_out <= g_slice[LAST].cout;
            ovfl      <= ovf_raw;
            zero      <= (res == '0);
            neg       <= res[WIDTH-1];
        end
    end
endmodule

// File: tb/tb_addsub_pipe.sv
// Directed and streaming checks of addsub_pipe at WIDTH=16 and WIDTH=4.
module tb_addsub_pipe;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        in_valid, in_ready, sub, sat, out_valid, out_ready, carry_out, ovfl, zero, neg;
    logic [15:0] a, b, sum;

    logic        w4_in_valid, w4_in_ready, w4_sub, w4_sat, w4_out_valid, w4_out_ready;
    logic        w4_carry_out, w4_ovfl, w4_zero, w4_neg;
    logic [3:0]  w4_a, w4_b, w4_sum;

    int n_run  = 0;
    int n_fail = 0;

    addsub_pipe #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .sat(sat), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .carry_out(carry_out), .ovfl(ovfl), .zero(zero), .neg(neg)
    );

    addsub_pipe #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(w4_in_valid), .in_ready(w4_in_ready),
        .a(w4_a), .b(w4_b), .sub(w4_sub), .sat(w4_sat), .out_valid(w4_out_valid),
        .out_ready(w4_out_ready), .sum(w4_sum), .carry_out(w4_carry_out), .ovfl(w4_ovfl),
        .zero(w4_zero), .neg(w4_neg)
    );

    typedef struct packed {
        logic [15:0] sum;
        logic        c, v, z, n;
    } res16_t;

    typedef struct packed {
        logic [15:0] a, b;
        logic        s, st;
        logic [15:0] sum;
        logic [3:0]  f;
    } vec16_t;

    typedef struct packed {
        logic [3:0] a, b;
        logic       s, st;
        logic [3:0] sum;
        logic [3:0] f;
    } vec4_t;

    // Independent reference: wide add, overflow from operand/result signs.
    function automatic res16_t model16(input logic [15:0] ta, input logic [15:0] tb,
                                       input logic ts, input logic tsat);
        logic [15:0] bb;
        logic [16:0] full;
        res16_t      r;
        bb    = ts ? ~tb : tb;
        full  = {1'b0, ta} + {1'b0, bb} + {16'd0, ts};
        r.c   = full[16];
        r.v   = (ta[15] == bb[15]) && (full[15] != ta[15]);
        r.sum = (tsat && r.v) ? (ta[15] ? 16'h8000 : 16'h7FFF) : full[15:0];
        r.z   = (r.sum == 16'h0000);
        r.n   = r.sum[15];
        return r;
    endfunction

    task automatic xact16(input logic [15:0] ta, input logic [15:0] tb, input logic ts,
                          input logic tsat, output int lat);
        a = ta; b = tb; sub = ts; sat = tsat; in_valid = 1'b1; out_ready = 1'b1;
        lat = 0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic xact4(input logic [3:0] ta, input logic [3:0] tb, input logic ts,
                         input logic tsat, output int lat);
        w4_a = ta; w4_b = tb; w4_sub = ts; w4_sat = tsat; w4_in_valid = 1'b1; w4_out_ready = 1'b1;
        lat = 0;
        @(posedge clk); #1;
        w4_in_valid = 1'b0;
        lat = 1;
        while (!w4_out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        out_ready = 1'b0; w4_out_ready = 1'b0;
        #12;
        n_run++;
        if ({out_valid, sum, carry_out, ovfl, zero, neg, in_ready} !== {1'b0, 16'h0000, 4'h0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset16: got v=%b s=%h c=%b o=%b z=%b n=%b r=%b, want all 0 and in_ready=1",
                     out_valid, sum, carry_out, ovfl, zero, neg, in_ready);
        end
        n_run++;
        if ({w4_out_valid, w4_sum, w4_carry_out, w4_ovfl, w4_zero, w4_neg, w4_in_ready} !== {1'b0, 4'h0, 4'h0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset4: got v=%b s=%h c=%b o=%b z=%b n=%b r=%b, want all 0 and in_ready=1",
                     w4_out_valid, w4_sum, w4_carry_out, w4_ovfl, w4_zero, w4_neg, w4_in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed16();
        vec16_t vec [7];
        int     lat;
        vec = '{
            '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 4'b0101},
            '{16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 4'b0100},
            '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h8000, 4'b1101},
            '{16'h1234, 16'h1234, 1'b1, 1'b0, 16'h0000, 4'b1010},
            '{16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 4'b0001},
            '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 4'b1110},
            '{16'h8000, 16'h8000, 1'b0, 1'b1, 16'h8000, 4'b1101}
        };
        for (int i = 0; i < 7; i++) begin
            xact16(vec[i].a, vec[i].b, vec[i].s, vec[i].st, lat);
            n_run++;
            if (lat !== 4) begin
                n_fail++;
                $display("FAIL dir16_%0d_latency: got %0d want 4", i, lat);
            end
            n_run++;
            if (sum !== vec[i].sum) begin
                n_fail++;
                $display("FAIL dir16_%0d_sum: got %h want %h", i, sum, vec[i].sum);
            end
            n_run++;
            if ({carry_out, ovfl, zero, neg} !== vec[i].f) begin
                n_fail++;
                $display("FAIL dir16_%0d_flags(c,o,z,n): got %b want %b", i,
                         {carry_out, ovfl, zero, neg}, vec[i].f);
            end
        end
    endtask

    task automatic test_w4();
        vec4_t vec [5];
        int    lat;
        vec = '{
            '{4'h7, 4'h1, 1'b0, 1'b1, 4'h7, 4'b0100},
            '{4'h7, 4'h1, 1'b0, 1'b0, 4'h8, 4'b0101},
            '{4'h3, 4'h5, 1'b1, 1'b0, 4'hE, 4'b0001},
            '{4'h8, 4'h8, 1'b0, 1'b1, 4'h8, 4'b1101},
            '{4'h0, 4'h0, 1'b1, 1'b0, 4'h0, 4'b1010}
        };
        for (int i = 0; i < 5; i++) begin
            xact4(vec[i].a, vec[i].b, vec[i].s, vec[i].st, lat);
            n_run++;
            if (lat !== 1) begin
                n_fail++;
                $display("FAIL w4_%0d_latency: got %0d want 1", i, lat);
            end
            n_run++;
            if ({w4_sum, w4_carry_out, w4_ovfl, w4_zero, w4_neg} !== {vec[i].sum, vec[i].f}) begin
                n_fail++;
                $display("FAIL w4_%0d_result(sum,c,o,z,n): got %h %b want %h %b", i,
                         w4_sum, {w4_carry_out, w4_ovfl, w4_zero, w4_neg}, vec[i].sum, vec[i].f);
            end
        end
    endtask

    task automatic test_back_to_back();
        res16_t      exp_q[$];
        res16_t      e;
        logic [15:0] pa, pb, held_sum;
        logic [4:0]  held_f;
        logic        ps, psat, have;
        int          sent, got, cyc;
        sent = 0; got = 0; cyc = 0; have = 1'b0;
        pa = '0; pb = '0; ps = 1'b0; psat = 1'b0; held_sum = '0; held_f = '0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        while (got < 100 && cyc < 400) begin
            out_ready = !(cyc >= 50 && cyc < 53);
            #1;
            if (cyc >= 50 && cyc < 53) begin
                n_run++;
                if (in_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL stall_in_ready cyc %0d: got %b want 0", cyc, in_ready);
                end
                if (cyc == 50) begin
                    held_sum = sum;
                    held_f   = {out_valid, carry_out, ovfl, zero, neg};
                    n_run++;
                    if (out_valid !== 1'b1) begin
                        n_fail++;
                        $display("FAIL stall_out_valid: got %b want 1", out_valid);
                    end
                end else begin
                    n_run++;
                    if ({sum, out_valid, carry_out, ovfl, zero, neg} !== {held_sum, held_f}) begin
                        n_fail++;
                        $display("FAIL stall_hold cyc %0d: got %h/%b want %h/%b", cyc, sum,
                                 {out_valid, carry_out, ovfl, zero, neg}, held_sum, held_f);
                    end
                end
            end
            if (out_valid && out_ready) begin
                n_run++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL stream_extra: got result %h with empty scoreboard", sum);
                end else begin
                    e = exp_q.pop_front();
                    if ({sum, carry_out, ovfl, zero, neg} !== {e.sum, e.c, e.v, e.z, e.n}) begin
                        n_fail++;
                        $display("FAIL stream_result %0d: got %h %b want %h %b", got, sum,
                                 {carry_out, ovfl, zero, neg}, e.sum, {e.c, e.v, e.z, e.n});
                    end
                end
                got++;
            end
            if (sent < 100) begin
                if (!have) begin
                    pa   = (sent % 10 == 3) ? 16'h7FFF : 16'($urandom);
                    pb   = (sent % 10 == 7) ? 16'h8000 : 16'($urandom);
                    ps   = 1'($urandom);
                    psat = 1'($urandom);
                    have = 1'b1;
                end
                a = pa; b = pb; sub = ps; sat = psat; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model16(pa, pb, ps, psat));
                sent++;
                have = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        n_run++;
        if (got !== 100 || sent !== 100 || exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL stream_count: got %0d sent %0d left %0d want 100/100/0", got, sent, exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        out_ready = 1'b1; w4_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a = 16'(16'h1111 * (i + 1)); b = 16'h2222; sub = 1'b0; sat = 1'b0; in_valid = 1'b1;
            w4_a = 4'h7; w4_b = 4'h1; w4_sub = 1'b0; w4_sat = 1'b1; w4_in_valid = (i == 3);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; w4_in_valid = 1'b0; out_ready = 1'b0; w4_out_ready = 1'b0;
        n_run++;
        if ({out_valid, sum} !== {1'b1, 16'h3333}) begin
            n_fail++;
            $display("FAIL pre_reset16: got v=%b sum=%h want v=1 sum=3333", out_valid, sum);
        end
        n_run++;
        if ({w4_out_valid, w4_sum, w4_ovfl} !== {1'b1, 4'h7, 1'b1}) begin
            n_fail++;
            $display("FAIL pre_reset4: got v=%b sum=%h o=%b want v=1 sum=7 o=1", w4_out_valid, w4_sum, w4_ovfl);
        end
        #1 rst_n = 1'b0;
        #1;
        n_run++;
        if ({out_valid, sum, carry_out, ovfl, zero, neg, in_ready} !== {1'b0, 16'h0000, 4'h0, 1'b1}) begin
            n_fail++;
            $display("FAIL mid_reset16: got v=%b s=%h c=%b o=%b z=%b n=%b r=%b, want all 0 and in_ready=1",
                     out_valid, sum, carry_out, ovfl, zero, neg, in_ready);
        end
        n_run++;
        if ({w4_out_valid, w4_sum, w4_carry_out, w4_ovfl, w4_zero, w4_neg, w4_in_ready} !== {1'b0, 4'h0, 4'h0, 1'b1}) begin
            n_fail++;
            $display("FAIL mid_reset4: got v=%b s=%h c=%b o=%b z=%b n=%b r=%b, want all 0 and in_ready=1",
                     w4_out_valid, w4_sum, w4_carry_out, w4_ovfl, w4_zero, w4_neg, w4_in_ready);
        end
        #2 rst_n = 1'b1;
        out_ready = 1'b1; w4_out_ready = 1'b1;
        seen = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
            if (w4_out_valid) seen++;
        end
        n_run++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL stale_after_reset: got %0d valid cycles want 0", seen);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; sat = 1'b0; out_ready = 1'b0;
        w4_in_valid = 1'b0; w4_a = '0; w4_b = '0; w4_sub = 1'b0; w4_sat = 1'b0; w4_out_ready = 1'b0;
        test_reset();
        test_directed16();
        test_w4();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
